// File: rtl/seg7_decoder_rx.sv
// Debounces an active-low 7-seg bus, decodes each newly stable pattern to hex; optional SEG7RX_SYNC_EN adds a 2-flop input synchroniser.
// Latency STABLE_CYCLES edges (+2 with sync); one-deep output, a commit while FULL and not ready is dropped and sets overrun.
module seg7_decoder_rx #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       resetb,
  input  logic [6:0] seg_in,
  input  logic       ready,
  input  logic       ovr_clr,
  output logic       valid,
  output logic [3:0] num,
  output logic       err,
  output logic       overrun
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] MAXC = CW'(STABLE_CYCLES);
  localparam logic [6:0] BLANK = 7'b1111111;

  typedef enum logic {EMPTY, FULL} state_t;

  logic [6:0]    s;
  logic [6:0]    cand_q, cand_d;
  logic [6:0]    last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          commit;
  logic          drop;
  logic [4:0]    dec;
  state_t        state_q;
  logic          valid_q;
  logic [3:0]    num_q;
  logic          err_q;
  logic          ovr_q;

  // Returns {err, num}.
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'b1111111: decode = 5'h00;
      7'b1111001: decode = 5'h01;
      7'b0100100: decode = 5'h02;
      7'b0110000: decode = 5'h03;
      7'b0011001: decode = 5'h04;
      7'b0010010: decode = 5'h05;
      7'b0000010: decode = 5'h06;
      7'b1111000: decode = 5'h07;
      7'b0000000: decode = 5'h08;
      7'b0011000: decode = 5'h09;
      7'b0001000: decode = 5'h0A;
      7'b0000011: decode = 5'h0B;
      7'b1000110: decode = 5'h0C;
      7'b0100001: decode = 5'h0D;
      7'b0000110: decode = 5'h0E;
      7'b0001110: decode = 5'h0F;
      default:    decode = 5'h10;
    endcase
  endfunction

`ifdef SEG7RX_SYNC_EN
  logic [6:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      sync1_q <= BLANK;
      sync2_q <= BLANK;
    end else begin
      sync1_q <= seg_in;
      sync2_q <= sync1_q;
    end
  end

  assign s = sync2_q;
`else
  assign s = seg_in;
`endif

  always_comb begin
    cnt_d  = CW'(1);
    cand_d = s;
    if (s == cand_q) cnt_d = (cnt_q >= MAXC) ? MAXC : cnt_q + CW'(1);
    // With STABLE_CYCLES==1 a fresh pattern commits on its first sample.
    commit = (cnt_d == MAXC) && ((s == cand_q) || (cnt_d == CW'(1))) && (s != last_q);
    last_d = commit ? s : last_q;
    dec    = decode(s);
    drop   = commit && (state_q == FULL) && !ready;
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      cand_q <= BLANK;
      cnt_q  <= '0;
      last_q <= BLANK;
    end else begin
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q <= EMPTY;
      valid_q <= 1'b0;
      num_q   <= 4'h0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (commit) begin
            state_q        <= FULL;
            valid_q        <= 1'b1;
            {err_q, num_q} <= dec;
          end
        end
        FULL: begin
          if (ready) begin
            if (commit) begin
              {err_q, num_q} <= dec;
            end else begin
              state_q <= EMPTY;
              valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= EMPTY;
          valid_q <= 1'b0;
        end
      endcase
      if (drop)         ovr_q <= 1'b1;
      else if (ovr_clr) ovr_q <= 1'b0;
    end
  end

  assign valid   = valid_q;
  assign num     = num_q;
  assign err     = err_q;
  assign overrun = ovr_q;

endmodule

// File: tb/tb_seg7_decoder_rx.sv
// Bench for seg7_decoder_rx (STABLE_CYCLES=4), table vectors plus handshake/reset corner sequences.
module tb_seg7_decoder_rx;

`ifdef SEG7RX_SYNC_EN
  localparam int EX = 2;
`else
  localparam int EX = 0;
`endif
  localparam int SC = 4;

  logic       clk = 1'b0;
  logic       resetb = 1'b0;
  logic [6:0] seg_in = 7'b1111111;
  logic       ready = 1'b0;
  logic       ovr_clr = 1'b0;
  logic       valid;
  logic [3:0] num;
  logic       err;
  logic       overrun;

  int n_vec = 0;
  int n_mis = 0;
  logic [4:0] exp_q[$];

  typedef struct {
    logic [6:0] seg;
    logic [3:0] num;
    logic       err;
  } vec_t;
  vec_t tbl[19];

  seg7_decoder_rx #(.STABLE_CYCLES(SC)) dut (
    .clk(clk), .resetb(resetb), .seg_in(seg_in), .ready(ready), .ovr_clr(ovr_clr),
    .valid(valid), .num(num), .err(err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetb  = 1'b0;
    seg_in  = 7'b1111111;
    ovr_clr = 1'b0;
    exp_q.delete();
    cyc(2);
    resetb = 1'b1;
  endtask

  // Scoreboard: every accepted transfer must match the oldest expected event.
  always @(negedge clk) begin
    if (resetb && valid && ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_mis++;
        $display("FAIL unexpected_event: got err=%0b num=%0h expected no event", err, num);
      end else begin
        chk("event", {27'd0, err, num}, {27'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    tbl[0]  = '{7'b1111001, 4'h1, 1'b0};
    tbl[1]  = '{7'b0100100, 4'h2, 1'b0};
    tbl[2]  = '{7'b0110000, 4'h3, 1'b0};
    tbl[3]  = '{7'b0011001, 4'h4, 1'b0};
    tbl[4]  = '{7'b0010010, 4'h5, 1'b0};
    tbl[5]  = '{7'b0000010, 4'h6, 1'b0};
    tbl[6]  = '{7'b1111000, 4'h7, 1'b0};
    tbl[7]  = '{7'b0000000, 4'h8, 1'b0};
    tbl[8]  = '{7'b0011000, 4'h9, 1'b0};
    tbl[9]  = '{7'b0001000, 4'hA, 1'b0};
    tbl[10] = '{7'b0000011, 4'hB, 1'b0};
    tbl[11] = '{7'b1000110, 4'hC, 1'b0};
    tbl[12] = '{7'b0100001, 4'hD, 1'b0};
    tbl[13] = '{7'b0000110, 4'hE, 1'b0};
    tbl[14] = '{7'b0001110, 4'hF, 1'b0};
    tbl[15] = '{7'b1111111, 4'h0, 1'b0};
    tbl[16] = '{7'b0110110, 4'h0, 1'b1};
    tbl[17] = '{7'b1111110, 4'h0, 1'b1};
    tbl[18] = '{7'b0001110, 4'hF, 1'b0};

    // Reset state
    #1;
    chk("rst_valid", valid, 0);
    chk("rst_num", num, 0);
    chk("rst_err", err, 0);
    chk("rst_ovr", overrun, 0);
    do_reset();

    // First commit latency and single event for a held pattern
    ready  = 1'b1;
    seg_in = 7'b0100100;
    exp_q.push_back(5'h02);
    cyc(SC - 1 + EX);
    chk("lat_before", valid, 0);
    cyc(1);
    chk("lat_valid", valid, 1);
    chk("lat_num", {err, num}, 5'h02);
    cyc(1);
    chk("lat_after", valid, 0);
    cyc(20);
    chk("hold_no_event", exp_q.size(), 0);

    // Short glitch never commits
    do_reset();
    ready  = 1'b1;
    seg_in = 7'b0110000;
    cyc(3);
    seg_in = 7'b1111111;
    cyc(SC + EX + 3);
    seg_in = 7'b0110000;
    exp_q.push_back(5'h03);
    cyc(SC + EX + 3);
    chk("glitch_then_event", exp_q.size(), 0);

    // Overrun with ready low
    do_reset();
    ready  = 1'b0;
    seg_in = 7'b1111001;
    exp_q.push_back(5'h01);
    cyc(SC + EX + 1);
    chk("ovr_valid", valid, 1);
    chk("ovr_num1", num, 1);
    seg_in = 7'b0000000;
    cyc(SC + EX + 1);
    chk("ovr_num_held", num, 1);
    chk("ovr_set", overrun, 1);
    ready = 1'b1;
    cyc(1);
    chk("ovr_xfer_valid", valid, 0);
    chk("ovr_xfer_done", exp_q.size(), 0);
    chk("ovr_sticky", overrun, 1);
    ovr_clr = 1'b1;
    cyc(1);
    ovr_clr = 1'b0;
    chk("ovr_clear", overrun, 0);

    // Back-to-back: 1 then blank decodes to 0
    do_reset();
    ready  = 1'b1;
    seg_in = 7'b1111001;
    exp_q.push_back(5'h01);
    cyc(SC + EX + 2);
    seg_in = 7'b1111111;
    exp_q.push_back(5'h00);
    cyc(SC + EX + 2);
    chk("b2b_drain", exp_q.size(), 0);

    // Table sweep over every legal code and some illegal ones
    do_reset();
    ready = 1'b1;
    for (int i = 0; i < 19; i++) begin
      seg_in = tbl[i].seg;
      exp_q.push_back({tbl[i].err, tbl[i].num});
      cyc(SC + EX + 2);
      chk($sformatf("tbl_drain_%0d", i), exp_q.size(), 0);
    end

    // Reset mid-filter
    do_reset();
    ready  = 1'b0;
    seg_in = 7'b0100100;
    cyc(2 + EX);
    resetb = 1'b0;
    #1;
    chk("midf_valid", valid, 0);
    chk("midf_ovr", overrun, 0);
    cyc(1);
    resetb = 1'b1;
    cyc(SC - 1 + EX);
    chk("midf_before", valid, 0);
    cyc(1);
    chk("midf_valid_hi", valid, 1);
    chk("midf_num", num, 2);

    // Reset mid-handshake: pending event lost, no overrun, recommit after release
    resetb = 1'b0;
    #1;
    chk("midh_valid", valid, 0);
    chk("midh_num", {err, num}, 0);
    chk("midh_ovr", overrun, 0);
    cyc(1);
    resetb = 1'b1;
    ready  = 1'b1;
    exp_q.push_back(5'h02);
    cyc(SC - 1 + EX);
    chk("midh_before", valid, 0);
    cyc(1);
    chk("midh_recommit", valid, 1);
    cyc(2);
    chk("midh_drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
